imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
Shares a single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV32I pipeline. It sequences one access at a time with data priority and discards fetches killed by a branch/jump redirect. It produces structural-stall signals that the pipeline top ORs with the hazard-unit stalls, and it keeps a stall-cycle counter and a timeout error flag.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables are DW/8 bits)
TO_CYC, 64, cycles without mem_ack before an access is aborted
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  AW  fetch address (PCF)
if_valid  out  1  fetch completes this cycle
if_rdata  out  DW  instruction, valid with if_valid
dm_req  in  1  load/store request, held until dm_valid
dm_we  in  1  1=store
dm_addr  in  AW  data address (ALUResultM)
dm_wdata  in  DW  store data
dm_be  in  DW/8  byte enables
dm_valid  out  1  data access completes this cycle
dm_rdata  out  DW  load data, valid with dm_valid
redirect  in  1  PCSrcE: the fetch in flight is wrong-path
mem_req  out  1  memory access request (registered)
mem_we  out  1  registered
mem_addr  out  AW  registered
mem_wdata  out  DW  registered
mem_be  out  DW/8  registered; all-ones for fetches
mem_ack  in  1  access complete; mem_rdata valid this cycle
mem_rdata  in  DW  memory read data
stall_f  out  1  hold PC and IF/ID
stall_m  out  1  freeze the whole pipeline
stall_cnt  out  CNT_W  cycles with stall_f or stall_m high, wraps
err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_be, err, stall_cnt and the timeout counter all go to 0. Any mem_ack after reset is ignored. Reset during an access abandons that access.
- States: IDLE, IF_BUSY, DM_BUSY, IF_KILL.
- IDLE:
  - dm_req=1: latch the dm_* inputs into the mem_* registers, set mem_req=1, go to DM_BUSY. This wins over if_req.
  - dm_req=0 and if_req=1 and redirect=0: latch if_addr, mem_we=0, mem_be all-ones, mem_req=1, go to IF_BUSY.
  - No request, or only if_req with redirect=1: stay in IDLE.
  - mem_ack is ignored in IDLE.
- Busy states: mem_* outputs are held stable until mem_ack. On the mem_ack cycle, mem_req drops at the next edge and the state returns to IDLE. Issue-to-issue spacing is therefore at least ack+2 cycles. Only one access is ever outstanding.
- Completion:
  - if_valid = mem_ack & (state==IF_BUSY) & ~redirect. if_rdata = mem_rdata (combinational).
  - dm_valid = mem_ack & (state==DM_BUSY). dm_rdata = mem_rdata.
- Redirect:
  - In IF_BUSY with redirect=1 and mem_ack=0: go to IF_KILL and wait for the ack.
  - On the ack in IF_KILL: if_valid=0, data discarded, go to IDLE.
  - redirect with ack in the same cycle in IF_BUSY: if_valid suppressed, go to IDLE.
  - redirect has no effect in DM_BUSY or IDLE.
- Stalls (combinational):
  - stall_f = if_req & ~if_valid.
  - stall_m = dm_req & ~dm_valid.
  - While an IF access or IF_KILL is in progress and dm_req rises, stall_m stays high until the data access completes; the data access is granted from the next IDLE.
- stall_cnt: increments by 1 on every cycle where stall_f|stall_m=1, wrapping modulo 2^CNT_W.
- Timeout:
  - The counter clears on state entry and counts busy cycles with mem_ack=0.
  - When it reaches TO_CYC-1 without an ack: set err=1 (sticky until rst), drop mem_req, go to IDLE, no valid pulse. The requester stays stalled and its req is re-arbitrated.
  - A mem_ack arriving in the same cycle as the timeout wins: normal completion, err unchanged.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req with rdata=0x00500093 -> mem_addr=0x100, mem_be=4'hF; if_valid=1 for one cycle with if_rdata=0x00500093; stall_f high every cycle before that; stall_cnt=3.
- Simultaneous requests from IDLE: if_req=1 (0x104) and dm_req=1 store (0x2000, wdata=0xDEADBEEF, be=4'b0011) -> data issued first with mem_we=1 and mem_be=4'b0011; fetch issued in the next IDLE after dm_valid; stall_m falls the cycle dm_valid=1.
- Redirect mid-fetch: in IF_BUSY, redirect pulses one cycle before mem_ack -> state IF_KILL, if_valid stays 0 on the ack, return to IDLE. A new if_req at 0x200 then issues normally. The same check is repeated with redirect coincident with mem_ack: if_valid=0.
- Timeout: TO_CYC=8, dm_req held, mem_ack never asserted -> err=1 after 8 busy cycles, mem_req=0, the access is reissued from IDLE, and err stays 1. With mem_ack arriving on the 8th busy cycle instead: dm_valid=1, err=0.
- Reset mid-access: assert rst in DM_BUSY, deassert, then drive a stale mem_ack -> mem_req=0, dm_valid=0, stall_cnt=0, err=0, state IDLE.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Memory-side bus of the unified instruction/data memory arbiter.
// The arbiter is the master; the single-port memory is the slave.
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic            ack;
  logic [DW-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one memory port,
// data first, dropping fetches killed by a redirect; drives structural stalls.
module imem_dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_valid,
  output logic [DW-1:0]     if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  input  logic [DW/8-1:0]   dm_be,
  output logic              dm_valid,
  output logic [DW-1:0]     dm_rdata,
  input  logic              redirect,
  imem_dmem_arbiter_if.master mem,
  output logic              stall_f,
  output logic              stall_m,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err
);

  localparam int BW = DW / 8;
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, IF_KILL} state_t;

  state_t        state, stateNext;
  logic [TW-1:0] toCnt;
  logic          busy, timeout, issueIf, issueDm;

  assign busy    = (state != IDLE);
  // An ack in the timeout cycle is a normal completion, so it masks the abort.
  assign timeout = busy & ~mem.ack & (toCnt == TO_LAST);

  assign if_valid = mem.ack & (state == IF_BUSY) & ~redirect;
  assign dm_valid = mem.ack & (state == DM_BUSY);
  assign if_rdata = mem.rdata;
  assign dm_rdata = mem.rdata;
  assign stall_f  = if_req & ~if_valid;
  assign stall_m  = dm_req & ~dm_valid;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    stateNext = state;
    issueIf   = 1'b0;
    issueDm   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req) begin
          issueDm   = 1'b1;
          stateNext = DM_BUSY;
        end else if (if_req && !redirect) begin
          issueIf   = 1'b1;
          stateNext = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (mem.ack || timeout) stateNext = IDLE;
        else if (redirect)      stateNext = IF_KILL;
      end
      DM_BUSY, IF_KILL: begin
        if (mem.ack || timeout) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      toCnt     <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      // NOTE: the memory-side datapath registers are reset too, so the bus
      // never shows stale X address/data to the memory after reset.
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.be    <= '0;
    end else begin
      state <= stateNext;

      if (stateNext != state)     toCnt <= '0;
      else if (busy && !mem.ack)  toCnt <= toCnt + 1'b1;

      if (timeout)             err       <= 1'b1;
      if (stall_f || stall_m)  stall_cnt <= stall_cnt + 1'b1;

      if (issueDm) begin
        mem.req   <= 1'b1;
        mem.we    <= dm_we;
        mem.addr  <= dm_addr;
        mem.wdata <= dm_wdata;
        mem.be    <= dm_be;
      end else if (issueIf) begin
        mem.req   <= 1'b1;
        mem.we    <= 1'b0;
        mem.addr  <= if_addr;
        mem.be    <= {BW{1'b1}};
      end else if (busy && (mem.ack || timeout)) begin
        mem.req   <= 1'b0;
      end
    end
  end

endmodule
